fifo: RTL and testbench
=======================

FIFO -- requirements
Module: fifo

Interface
REQ-001 The module SHALL have a parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The module SHALL have a parameter ADDR_W, default 2, with DEPTH = 2**ADDR_W entries (4 by default).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port data_in, input, WIDTH bits: the word to enqueue.
REQ-006 The module SHALL have port push, input, 1 bit: enqueue request, rising-edge detected.
REQ-007 The module SHALL have port pop, input, 1 bit: dequeue request, rising-edge detected.
REQ-008 The module SHALL have port data_out, output, WIDTH bits: the head-of-queue word (first-word fall-through).
REQ-009 The module SHALL have port empty, output, 1 bit: high when 0 entries are stored.
REQ-010 The module SHALL have port full, output, 1 bit: high when DEPTH entries are stored.

Function
REQ-011 The module SHALL register push and pop into push_q and pop_q every clock.
REQ-012 The module SHALL form push_evt = push & ~push_q and pop_evt = pop & ~pop_q, so a request held high for N cycles is exactly one event.
REQ-013 On push_evt with not full, the module SHALL write data_in to mem[wr_ptr], increment wr_ptr modulo DEPTH and increment count.
REQ-014 On pop_evt with not empty, the module SHALL increment rd_ptr modulo DEPTH and decrement count.
REQ-015 The module SHALL drive data_out combinationally as mem[rd_ptr], so the oldest word is visible before any pop and the next word is visible in the cycle after a pop.
REQ-016 When empty, data_out SHALL show mem[rd_ptr], stale content; consumers shall ignore it.
REQ-017 The module SHALL set empty = (count == 0) and full = (count == DEPTH), both registered-state derived with no extra latency.
REQ-018 The module SHALL hold a count of ADDR_W+1 bits so that DEPTH is representable.
REQ-019 The module SHALL ignore push_evt while full, leaving pointers, count and memory unchanged.
REQ-020 The module SHALL ignore pop_evt while empty, leaving state unchanged.
REQ-021 On simultaneous push_evt and pop_evt with 0 < count < DEPTH, the module SHALL perform both and keep count unchanged.
REQ-022 On simultaneous push_evt and pop_evt while empty, the module SHALL perform only the write.
REQ-023 On simultaneous push_evt and pop_evt while full, the module SHALL perform both (read then write into the freed slot) and keep full asserted.

Reset
REQ-024 Asserting reset SHALL immediately clear wr_ptr, rd_ptr, count, push_q, pop_q and all memory entries to 0, giving empty=1, full=0 and data_out=0.
REQ-025 Reset asserted mid-operation SHALL discard all contents, and no push_evt or pop_evt SHALL be taken while reset is high.
REQ-026 A request already high when reset deasserts SHALL count as one event on the first clock edge after deassertion.

Configuration
REQ-027 With macro FIFO_ERR_FLAGS_EN defined, the module SHALL add outputs overflow and underflow (1 bit each), set sticky on a push_evt while full or a pop_evt while empty, and cleared only by reset.
REQ-028 Without FIFO_ERR_FLAGS_EN defined, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset then one pop pulse -> empty=1, full=0 throughout, and no state change.
REQ-030 push held 5 cycles with data_in=0 -> exactly one entry stored; empty=0, full=0, data_out=0.
REQ-031 Single-cycle pushes of 1, 2, 3 -> full=1 after the third; a further push of 1 is ignored and full stays 1.
REQ-032 Four single-cycle pops -> data_out reads 1, 2, 3 after pops 1-3 with full=0; after pop 4, empty=1.
REQ-033 With 2 entries, push and pop rising in the same cycle -> count stays 2, the head advances, and the new word appears last in order.
REQ-034 With FIFO_ERR_FLAGS_EN defined, a push while full sets overflow, a pop while empty sets underflow, and reset clears both.

Source files
------------

// File: rtl/fifo.sv
// Synchronous FIFO with first-word fall-through output and edge-detected requests.
//
// A push or pop request held high for several cycles is taken as a single event;
// only its rising edge (relative to the previous clock) enqueues or dequeues.
// The head word is always driven combinationally from storage, so the oldest
// entry is visible before any pop. When empty, data_out shows stale storage.
//
// Parameters:
//   WIDTH    data word width in bits
//   ADDR_W   pointer width; DEPTH = 2**ADDR_W entries
//
// Ports:
//   clk        single clock, all state updates on its rising edge
//   reset      asynchronous active-high reset; clears pointers, count and storage
//   data_in    word to enqueue
//   push       enqueue request (rising-edge detected)
//   pop        dequeue request (rising-edge detected)
//   data_out   head-of-queue word
//   empty      high when no entries are stored
//   full       high when DEPTH entries are stored
//   overflow   (FIFO_ERR_FLAGS_EN only) sticky: push event seen while full
//   underflow  (FIFO_ERR_FLAGS_EN only) sticky: pop event seen while empty
//
// Build option: define FIFO_ERR_FLAGS_EN to add the overflow/underflow outputs.

module fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthCount = (ADDR_W + 1)'(DEPTH);

  logic             push_q, pop_q;
  logic             push_evt, pop_evt;
  logic             do_write, do_read;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  // Request edge detection: one event per low-to-high transition.
  always_comb begin
    push_evt = push & ~push_q;
    pop_evt  = pop & ~pop_q;
  end

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == DepthCount);
  end

  // A push while full is accepted only alongside a pop, which frees the slot
  // the write pointer already points at. A pop while empty is always dropped.
  always_comb begin
    do_read  = pop_evt & ~empty;
    do_write = push_evt & (~full | pop_evt);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_write) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_read) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_write, do_read})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      push_q   <= push;
      pop_q    <= pop;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_write) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out = mem_q[rd_ptr_q];

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (push_evt & full);
      underflow_q <= underflow_q | (pop_evt & empty);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the FIFO's rules.

module tb_fifo;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEPTH  = 4;

  logic             clk;
  logic             reset;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
`ifdef FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  fifo #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .push    (push),
    .pop     (pop),
    .data_out(data_out),
    .empty   (empty),
    .full    (full)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: a queue of stored words plus last-seen request levels.
  logic [WIDTH-1:0] model_q[$];
  logic             prev_push;
  logic             prev_pop;
  logic             m_ovf;
  logic             m_udf;

  function automatic logic m_empty();
    return model_q.size() == 0;
  endfunction

  function automatic logic m_full();
    return model_q.size() == DEPTH;
  endfunction

  task automatic model_clear();
    model_q.delete();
    prev_push = 1'b0;
    prev_pop  = 1'b0;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample 1ns later.
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d);
    logic pe, qe, was_empty, was_full;
    push    = p;
    pop     = q;
    data_in = d;
    @(posedge clk);
    pe        = p && !prev_push;
    qe        = q && !prev_pop;
    prev_push = p;
    prev_pop  = q;
    was_empty = m_empty();
    was_full  = m_full();
    if (pe && was_full) m_ovf = 1'b1;
    if (qe && was_empty) m_udf = 1'b1;
    if (qe && !was_empty) void'(model_q.pop_front());
    if (pe && (!was_full || qe)) model_q.push_back(d);
    #1;
  endtask

  task automatic pulse_push(input logic [WIDTH-1:0] d);
    step(1'b1, 1'b0, d);
    step(1'b0, 1'b0, d);
  endtask

  task automatic pulse_pop();
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    model_clear();
    repeat (2) @(negedge clk);
    checks++;
    if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty);
    else passes++;
    checks++;
    if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full);
    else passes++;
    checks++;
    if (data_out !== '0) $display("FAIL reset_data: got %0h want 0", data_out);
    else passes++;
    reset = 1'b0;
    // A lone pop after reset must leave the FIFO empty.
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if (empty !== 1'b1 || full !== 1'b0)
      $display("FAIL pop_after_reset: got empty=%b full=%b want empty=1 full=0", empty, full);
    else passes++;
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== '0)
      $display("FAIL pop_after_reset_hold: got e=%b f=%b d=%0h want e=1 f=0 d=0",
               empty, full, data_out);
    else passes++;
  endtask

  task automatic test_hold_push();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (empty !== 1'b0 || full !== 1'b0 || data_out !== 8'h00)
      $display("FAIL hold_push: got e=%b f=%b d=%0h want e=0 f=0 d=0", empty, full, data_out);
    else passes++;
  endtask

  task automatic test_fill();
    for (int v = 1; v <= 3; v++) begin
      pulse_push(WIDTH'(v));
      checks++;
      if (full !== m_full() || empty !== 1'b0)
        $display("FAIL fill_%0d: got f=%b e=%b want f=%b e=0", v, full, empty, m_full());
      else passes++;
    end
    checks++;
    if (full !== 1'b1) $display("FAIL fill_full: got %b want 1", full);
    else passes++;
    pulse_push(8'h01);
    checks++;
    if (full !== 1'b1 || data_out !== 8'h00)
      $display("FAIL push_when_full: got f=%b d=%0h want f=1 d=0", full, data_out);
    else passes++;
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 4; i++) begin
      pulse_pop();
      if (i < 4) begin
        checks++;
        if (data_out !== WIDTH'(i) || full !== 1'b0 || empty !== 1'b0)
          $display("FAIL drain_%0d: got d=%0h f=%b e=%b want d=%0h f=0 e=0",
                   i, data_out, full, empty, i);
        else passes++;
      end else begin
        checks++;
        if (empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty);
        else passes++;
      end
    end
  endtask

  task automatic test_simultaneous();
    pulse_push(8'h10);
    pulse_push(8'h20);
    step(1'b1, 1'b1, 8'h30);
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (data_out !== 8'h20 || empty !== 1'b0 || full !== 1'b0)
      $display("FAIL simul_head: got d=%0h e=%b f=%b want d=20 e=0 f=0", data_out, empty, full);
    else passes++;
    pulse_pop();
    checks++;
    if (data_out !== 8'h30 || empty !== 1'b0)
      $display("FAIL simul_order: got d=%0h e=%b want d=30 e=0", data_out, empty);
    else passes++;
    pulse_pop();
    checks++;
    if (empty !== 1'b1) $display("FAIL simul_empty: got %b want 1", empty);
    else passes++;
    // Both while empty: only the write happens.
    step(1'b1, 1'b1, 8'h44);
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (empty !== 1'b0 || data_out !== 8'h44)
      $display("FAIL simul_from_empty: got e=%b d=%0h want e=0 d=44", empty, data_out);
    else passes++;
    pulse_pop();
  endtask

  task automatic test_full_simultaneous();
    for (int i = 0; i < 4; i++) pulse_push(WIDTH'(8'hA0 + i));
    step(1'b1, 1'b1, 8'hA4);
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (full !== 1'b1 || data_out !== 8'hA1)
      $display("FAIL full_simul: got f=%b d=%0h want f=1 d=a1", full, data_out);
    else passes++;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (data_out !== WIDTH'(8'hA0 + i))
        $display("FAIL full_simul_order_%0d: got %0h want %0h", i, data_out, 8'hA0 + i);
      else passes++;
      pulse_pop();
    end
    checks++;
    if (empty !== 1'b1) $display("FAIL full_simul_empty: got %b want 1", empty);
    else passes++;
  endtask

  task automatic test_reset_mid();
    pulse_push(8'h11);
    pulse_push(8'h22);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== '0)
      $display("FAIL reset_mid: got e=%b f=%b d=%0h want e=1 f=0 d=0", empty, full, data_out);
    else passes++;
    // Toggle requests under reset; none may be taken.
    for (int i = 0; i < 4; i++) begin
      push = i[0];
      pop  = ~i[0];
      @(negedge clk);
    end
    checks++;
    if (empty !== 1'b1) $display("FAIL reset_no_evt: got %b want 1", empty);
    else passes++;
    push    = 1'b1;
    pop     = 1'b0;
    data_in = 8'h5A;
    reset   = 1'b0;
    // push already high at release counts as one event on the first edge.
    step(1'b1, 1'b0, 8'h5A);
    step(1'b1, 1'b0, 8'h66);
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (empty !== 1'b0 || data_out !== 8'h5A)
      $display("FAIL push_at_release: got e=%b d=%0h want e=0 d=5a", empty, data_out);
    else passes++;
    for (int i = 0; i < 3; i++) pulse_push(8'h70);
    checks++;
    if (full !== 1'b1) $display("FAIL release_single_evt: got f=%b want 1", full);
    else passes++;
    apply_reset();
  endtask

  task automatic test_random();
    logic p, q;
    logic [WIDTH-1:0] d;
    for (int n = 0; n < 400; n++) begin
      p = 1'($urandom_range(0, 1));
      q = 1'($urandom_range(0, 1));
      d = WIDTH'($urandom);
      step(p, q, d);
      checks++;
      if (empty !== m_empty() || full !== m_full())
        $display("FAIL rand_flags_%0d: got e=%b f=%b want e=%b f=%b",
                 n, empty, full, m_empty(), m_full());
      else passes++;
      if (!m_empty()) begin
        checks++;
        if (data_out !== model_q[0])
          $display("FAIL rand_data_%0d: got %0h want %0h", n, data_out, model_q[0]);
        else passes++;
      end
`ifdef FIFO_ERR_FLAGS_EN
      checks++;
      if (overflow !== m_ovf || underflow !== m_udf)
        $display("FAIL rand_err_%0d: got o=%b u=%b want o=%b u=%b",
                 n, overflow, underflow, m_ovf, m_udf);
      else passes++;
`endif
    end
  endtask

`ifdef FIFO_ERR_FLAGS_EN
  task automatic test_err_flags();
    apply_reset();
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL err_reset: got o=%b u=%b want 0 0", overflow, underflow);
    else passes++;
    pulse_pop();
    checks++;
    if (underflow !== 1'b1 || overflow !== 1'b0)
      $display("FAIL err_underflow: got o=%b u=%b want o=0 u=1", overflow, underflow);
    else passes++;
    for (int i = 0; i < 5; i++) pulse_push(WIDTH'(i));
    checks++;
    if (overflow !== 1'b1) $display("FAIL err_overflow: got %b want 1", overflow);
    else passes++;
    apply_reset();
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL err_cleared: got o=%b u=%b want 0 0", overflow, underflow);
    else passes++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hold_push();
    test_fill();
    test_drain();
    test_simultaneous();
    test_full_simultaneous();
    test_reset_mid();
    test_random();
`ifdef FIFO_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
